// File: rtl/hdmi_tmds_encoder.sv
// TMDS encoder for HDMI: NUM_CH independent lanes sharing one mode (CTL, VIDEO, TERC4 data, guard).
// Three register stages: input/minimise, q_m + balance, DC-balance/output.
module hdmi_tmds_encoder #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DISP_W = 6
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  gb_sel,
  input  logic [2*NUM_CH-1:0]   ctl,
  input  logic [8*NUM_CH-1:0]   pdata,
  input  logic [4*NUM_CH-1:0]   aux,
  output logic [10*NUM_CH-1:0]  tmds_data,
  output logic [1:0]            mode_out
);

  localparam logic [1:0] ModeCtl   = 2'b00;
  localparam logic [1:0] ModeVideo = 2'b01;
  localparam logic [1:0] ModeData  = 2'b10;
  localparam logic [1:0] ModeGuard = 2'b11;

  localparam logic [9:0] GbEven = 10'b1011001100;
  localparam logic [9:0] GbOdd  = 10'b0100110011;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Transition minimisation: XOR or XNOR chain, q[8] records which (1 = XOR).
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Ones minus zeros of q_m[7:0]; 5-bit wraparound gives the correct -8..+8.
  function automatic logic signed [4:0] balance(input logic [7:0] q);
    logic [4:0] n1x2;
    n1x2 = '0;
    for (int i = 0; i < 8; i++) n1x2 = n1x2 + {3'b000, q[i], 1'b0};
    return $signed(n1x2) - 5'sd8;
  endfunction

  logic [1:0] s1_mode, s2_mode;
  logic       s1_gb, s2_gb;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_mode  <= ModeCtl;
      s2_mode  <= ModeCtl;
      s1_gb    <= 1'b0;
      s2_gb    <= 1'b0;
      mode_out <= ModeCtl;
    end else begin
      s1_mode  <= mode;
      s2_mode  <= s1_mode;
      s1_gb    <= gb_sel;
      s2_gb    <= s1_gb;
      mode_out <= s2_mode;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam bit IsFirst = (ch == 0);
    localparam bit IsOdd   = ((ch % 2) == 1);

    logic [8:0]               s1_qm, s2_qm;
    logic [1:0]               s1_ctl, s2_ctl;
    logic [3:0]               s1_aux, s2_aux;
    logic signed [4:0]        s2_diff;
    logic signed [DISP_W-1:0] disp_q, disp_d, diff_x, two_q8, two_nq8;
    logic [9:0]               sym_q, sym_d;
    logic                     disp_pos, disp_neg, diff_pos, diff_neg;

    always_comb begin
      diff_x   = {{(DISP_W-5){s2_diff[4]}}, s2_diff};
      two_q8   = s2_qm[8] ? DISP_W'(2) : '0;
      two_nq8  = s2_qm[8] ? '0 : DISP_W'(2);
      disp_neg = disp_q[DISP_W-1];
      disp_pos = !disp_q[DISP_W-1] && (disp_q != '0);
      diff_neg = diff_x[DISP_W-1];
      diff_pos = !diff_x[DISP_W-1] && (diff_x != '0);
      sym_d    = ctl_code(s2_ctl);
      disp_d   = '0;
      case (s2_mode)
        ModeVideo: begin
          if ((disp_q == '0) || (diff_x == '0)) begin
            sym_d  = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            disp_d = s2_qm[8] ? (disp_q + diff_x) : (disp_q - diff_x);
          end else if ((disp_pos && diff_pos) || (disp_neg && diff_neg)) begin
            sym_d  = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            disp_d = disp_q + two_q8 - diff_x;
          end else begin
            sym_d  = {1'b0, s2_qm[8], s2_qm[7:0]};
            disp_d = disp_q + diff_x - two_nq8;
          end
        end
        ModeData: sym_d = terc4_code(s2_aux);
        ModeGuard: begin
          if (s2_gb) sym_d = IsFirst ? terc4_code(s2_aux) : GbOdd;
          else       sym_d = IsOdd ? GbOdd : GbEven;
        end
        default: sym_d = ctl_code(s2_ctl);
      endcase
    end

    always_ff @(posedge pixel_clk) begin
      if (rst) begin
        s1_qm   <= '0;
        s1_ctl  <= 2'b00;
        s1_aux  <= '0;
        s2_qm   <= '0;
        s2_ctl  <= 2'b00;
        s2_aux  <= '0;
        s2_diff <= '0;
        sym_q   <= ctl_code(2'b00);
        disp_q  <= '0;
      end else begin
        s1_qm   <= minimise(pdata[8*ch +: 8]);
        s1_ctl  <= ctl[2*ch +: 2];
        s1_aux  <= aux[4*ch +: 4];
        s2_qm   <= s1_qm;
        s2_ctl  <= s1_ctl;
        s2_aux  <= s1_aux;
        s2_diff <= balance(s1_qm[7:0]);
        sym_q   <= sym_d;
        disp_q  <= disp_d;
      end
    end

    assign tmds_data[10*ch +: 10] = sym_q;
  end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder (3 lanes): directed vectors with hand-derived symbols.
module tb_hdmi_tmds_encoder;

  localparam logic [1:0] MCtl = 2'b00, MVid = 2'b01, MDat = 2'b10, MGrd = 2'b11;
  localparam logic [9:0] C00 = 10'b1101010100, C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100, C11 = 10'b1010101011;
  localparam logic [9:0] GbE = 10'b1011001100, GbO = 10'b0100110011;
  localparam logic [29:0] IdleWord = {C00, C00, C00};

  typedef struct {
    logic [1:0]  mode;
    logic [29:0] data;
    string       name;
  } exp_t;

  logic        pixel_clk;
  logic        rst;
  logic [1:0]  mode;
  logic        gb_sel;
  logic [5:0]  ctl;
  logic [23:0] pdata;
  logic [11:0] aux;
  logic [29:0] tmds_data;
  logic [1:0]  mode_out;

  exp_t        sbq[$];
  exp_t        cur;
  logic [2:0]  v;
  logic        issue_v;
  logic        chk_idle;
  logic [9:0]  terc[16];
  int          total;
  int          bad;

  hdmi_tmds_encoder #(.NUM_CH(3), .DISP_W(6)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .mode      (mode),
    .gb_sel    (gb_sel),
    .ctl       (ctl),
    .pdata     (pdata),
    .aux       (aux),
    .tmds_data (tmds_data),
    .mode_out  (mode_out)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  // Tracks which sampled inputs should be on the output now; reset discards in-flight ones.
  always @(posedge pixel_clk) begin
    if (rst) v <= 3'b000;
    else     v <= {v[1:0], issue_v};
  end

  always @(negedge pixel_clk) begin
    if (v[2]) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL underflow: got mode=%b data=%b with nothing expected", mode_out, tmds_data);
      end else begin
        cur = sbq.pop_front();
        if (tmds_data !== cur.data || mode_out !== cur.mode) begin
          bad++;
          $display("FAIL %s: got mode=%b data=%b, want mode=%b data=%b",
                   cur.name, mode_out, tmds_data, cur.mode, cur.data);
        end
      end
    end else if (chk_idle) begin
      total++;
      if (tmds_data !== IdleWord || mode_out !== MCtl) begin
        bad++;
        $display("FAIL idle_after_reset: got mode=%b data=%b, want mode=%b data=%b",
                 mode_out, tmds_data, MCtl, IdleWord);
      end
    end
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic g, input logic [5:0] c,
                       input logic [23:0] p, input logic [11:0] a, input logic [29:0] e,
                       input string nm);
    exp_t x;
    mode    = m;
    gb_sel  = g;
    ctl     = c;
    pdata   = p;
    aux     = a;
    issue_v = 1'b1;
    x.mode  = m;
    x.data  = e;
    x.name  = nm;
    sbq.push_back(x);
    step();
  endtask

  task automatic vid(input logic [23:0] p, input logic [29:0] e, input string nm);
    issue(MVid, 1'b0, 6'b000000, p, 12'h000, e, nm);
  endtask

  task automatic ctlv(input logic [5:0] c, input logic [29:0] e, input string nm);
    issue(MCtl, 1'b0, c, 24'h3C3C3C, 12'h000, e, nm);
  endtask

  initial begin
    terc[0]  = 10'b1010011100; terc[1]  = 10'b1001100011;
    terc[2]  = 10'b1011100100; terc[3]  = 10'b1011100010;
    terc[4]  = 10'b0101110001; terc[5]  = 10'b0100011110;
    terc[6]  = 10'b0110001110; terc[7]  = 10'b0100111100;
    terc[8]  = 10'b1011001100; terc[9]  = 10'b0100111001;
    terc[10] = 10'b0110011100; terc[11] = 10'b1011000110;
    terc[12] = 10'b1010001110; terc[13] = 10'b1001110001;
    terc[14] = 10'b0101100011; terc[15] = 10'b1011000011;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    issue_v  = 1'b0;
    chk_idle = 1'b0;
    mode     = MVid;
    gb_sel   = 1'b1;
    ctl      = 6'b111111;
    pdata    = 24'hA5C3F0;
    aux      = 12'h9E3;
    repeat (3) step();

    // Reset state, then two more idle symbols before the first input-derived one.
    chk_idle = 1'b1;
    rst      = 1'b0;
    vid(24'h000000, {3{10'b0100000000}}, "v00_first");
    vid(24'h000000, {3{10'b1111111111}}, "v00_second");
    vid(24'h000000, {3{10'b0100000000}}, "v00_third");
    chk_idle = 1'b0;
    ctlv(6'b100100, {C10, C01, C00}, "ctl_mixed");
    vid(24'hFFFFFF, {3{10'b1000000000}}, "vFF_from_zero");
    ctlv(6'b010101, {C01, C01, C01}, "ctl_01");
    vid(24'hFFFFFF, {3{10'b1000000000}}, "vFF_after_ctl_clear");
    ctlv(6'b111111, {C11, C11, C11}, "ctl_11");

    // Lanes diverge: ch0=0x01, ch1=0xFE, ch2=0xFF.
    vid(24'hFFFE01, {10'b1000000000, 10'b1011111111, 10'b0111111111}, "vmix_1");
    vid(24'hFFFE01, {10'b0011111111, 10'b0000000000, 10'b1100000000}, "vmix_2");
    vid(24'hFFFE01, {10'b0011111111, 10'b1011111111, 10'b1100000000}, "vmix_3");
    vid(24'hFFFE01, {10'b1000000000, 10'b0000000000, 10'b0111111111}, "vmix_4");
    vid(24'hAA5510, {10'b1000110011, 10'b0100110011, 10'b0111110000}, "vmix_diff0");

    for (int k = 0; k < 16; k++) begin
      logic [3:0] n;
      n = 4'(k);
      issue(MDat, 1'b0, 6'b000000, 24'h5A5A5A, {n, n, n}, {terc[k], terc[k], terc[k]},
            $sformatf("terc4_%0h", k));
    end

    issue(MGrd, 1'b0, 6'b000000, 24'h000000, 12'h375, {GbE, GbO, GbE}, "guard_video");
    issue(MGrd, 1'b1, 6'b000000, 24'h000000, 12'h375, {GbO, GbO, terc[5]}, "guard_data");
    vid(24'h000000, {3{10'b0100000000}}, "v00_after_guard");

    vid(24'hFE0110, {10'b1011111111, 10'b0111111111, 10'b0111110000}, "alt_v1");
    ctlv(6'b000000, {C00, C00, C00}, "alt_c1");
    vid(24'hFFAA55, {10'b1000000000, 10'b1000110011, 10'b0100110011}, "alt_v2");
    ctlv(6'b111001, {C11, C10, C01}, "alt_c2");
    vid(24'h01FF00, {10'b0111111111, 10'b1000000000, 10'b0100000000}, "alt_v3");
    ctlv(6'b000000, {C00, C00, C00}, "alt_c3");

    // Mid-burst reset: the last two issued symbols are in flight and must never appear.
    vid(24'h010101, {3{10'b0111111111}}, "pre_rst");
    vid(24'h010101, {3{10'b1100000000}}, "lost_a");
    vid(24'h010101, {3{10'b1100000000}}, "lost_b");
    rst     = 1'b1;
    issue_v = 1'b0;
    step();
    sbq.delete();
    chk_idle = 1'b1;
    step();
    step();
    rst = 1'b0;
    vid(24'h000000, {3{10'b0100000000}}, "post_rst_1");
    vid(24'h000000, {3{10'b1111111111}}, "post_rst_2");
    vid(24'h000000, {3{10'b0100000000}}, "post_rst_3");
    chk_idle = 1'b0;
    issue_v  = 1'b0;
    mode     = MCtl;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_tmds_encoder.md
HDMI_TMDS_ENCODER -- requirements
Module: hdmi_tmds_encoder

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of independently encoded TMDS channels (legal range 1..8).
REQ-002 The block SHALL have parameter DISP_W, default 6, giving the signed running-disparity register width per channel.
REQ-003 The block SHALL have input pixel_clk, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have input mode, width 2: 00 CTL, 01 VIDEO, 10 DATA (TERC4), 11 GUARD; shared by all channels.
REQ-006 The block SHALL have input gb_sel, width 1: in GUARD mode, 0 selects the video guard band and 1 selects the data-island guard band.
REQ-007 The block SHALL have input ctl, width 2*NUM_CH: control bits; ctl[2i+1:2i] belongs to channel i.
REQ-008 The block SHALL have input pdata, width 8*NUM_CH: video pixel bytes; pdata[8i+7:8i] belongs to channel i.
REQ-009 The block SHALL have input aux, width 4*NUM_CH: TERC4 nibbles; aux[4i+3:4i] belongs to channel i.
REQ-010 The block SHALL have output tmds_data, width 10*NUM_CH: registered 10-bit symbols; tmds_data[10i+9:10i] belongs to channel i.
REQ-011 The block SHALL have output mode_out, width 2: the mode value aligned with tmds_data.

Function
REQ-012 The block SHALL pipeline the data path with fixed latency: inputs sampled at edge N appear on tmds_data/mode_out after edge N+2, in every mode.
REQ-013 The block SHALL carry mode, gb_sel, ctl and aux through the pipeline alongside the video data, so the final stage decides on stage-aligned sideband only; no raw input reaches the output stage.
REQ-014 In VIDEO stage 1, the block SHALL count the ones in the byte (n1) and select the XNOR chain (q_m[8]=0) if n1>4 or (n1==4 and d[0]==0), else the XOR chain (q_m[8]=1); q_m[0]=d[0].
REQ-015 In VIDEO stage 2, the block SHALL register q_m[8:0] and the signed difference diff=N1(q_m[7:0])-N0(q_m[7:0]), range -8..+8.
REQ-016 In VIDEO, if disp==0 or diff==0, the block SHALL output {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}, with disp += q_m8 ? diff : -diff.
REQ-017 In VIDEO, if (disp>0 and diff>0) or (disp<0 and diff<0), the block SHALL output {1, q_m8, ~q_m[7:0]}, with disp += 2*q_m8 - diff.
REQ-018 In VIDEO, otherwise, the block SHALL output {0, q_m8, q_m[7:0]}, with disp += diff - 2*(~q_m8).
REQ-019 The block SHALL keep disparity arithmetic in DISP_W-bit two's complement; |disp| never exceeds 10, so no saturation or wrap logic is required.
REQ-020 In CTL, the block SHALL output per channel (bit 9 first) ctl 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-021 In DATA, the block SHALL output per channel the TERC4 code of aux (bit 9 first) 0:1010011100 1:1001100011 2:1011100100 3:1011100010 4:0101110001 5:0100011110 6:0110001110 7:0100111100.
REQ-022 The TERC4 table SHALL continue 8:1011001100 9:0100111001 A:0110011100 B:1011000110 C:1010001110 D:1001110001 E:0101100011 F:1011000011.
REQ-023 In GUARD with gb_sel=0, even channels SHALL output 1011001100 and odd channels 0100110011.
REQ-024 In GUARD with gb_sel=1, channel 0 SHALL output the TERC4 code of its aux and all other channels 0100110011.
REQ-025 In any non-VIDEO output cycle, the block SHALL clear every channel's disparity to 0, so the first VIDEO symbol after CTL/DATA/GUARD starts from disp=0.
REQ-026 On a mode change between consecutive cycles, each output symbol SHALL follow its own aligned mode, with no symbol lost or repeated.
REQ-027 Channels SHALL be fully independent; per-channel disparity SHALL NOT depend on other channels.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set all pipeline stages to mode=CTL with ctl=00, every tmds_data lane to 1101010100, mode_out to 00, and all disparities to 0.
REQ-029 After rst deasserts at edge R, outputs SHALL stay 1101010100 through edge R+1; the first input-derived symbol appears after edge R+2.
REQ-030 rst asserted mid-stream SHALL discard in-flight pipeline contents without emitting partial symbols.

Verification
REQ-031 Reset, then VIDEO with pdata=0x00 on channel 0 for three cycles -> 0100000000, 1111111111, 0100000000; disp 0 -> -8 -> +2 -> -6.
REQ-032 Reset, then VIDEO with pdata=0xFF for one cycle -> 1000000000, disp = -8; then CTL with ctl=01 -> 0010101011, disp = 0.
REQ-033 DATA mode sweeping aux 0..F on all channels -> the exact TERC4 table of REQ-021/REQ-022, each symbol 2 cycles after its input, mode_out = 10.
REQ-034 GUARD mode with NUM_CH=3, gb_sel=0 -> 1011001100, 0100110011, 1011001100; gb_sel=1 with aux0=5 -> 0100011110, 0100110011, 0100110011.
REQ-035 Alternating VIDEO/CTL every cycle with random pdata -> each symbol matches a reference model with disp reset per REQ-025; rst pulsed mid-burst -> 1101010100 per REQ-029.
REQ-036 Random VIDEO for 10^5 cycles with NUM_CH=4 -> every lane matches the DVI 1.0 model and |disp| <= 10 throughout.
